// File: rtl/pin_link_test.sv
// Board-to-board link test: drives TX lanes with PRBS7/toggle patterns and
// checks RX lanes with self-synchronising per-lane checkers.
module pin_link_test #(
  parameter int unsigned TX_LANES = 4,
  parameter int unsigned RX_LANES = 1,
  parameter int unsigned TEST_LEN = 1024,
  parameter int unsigned LOCK_CNT = 8,
  parameter int unsigned ERR_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [1:0]                pat_mode,
  input  logic [TX_LANES-1:0]       pin_txd,
  output logic                      pin_rxd,
  output logic [TX_LANES-1:0]       txd,
  input  logic [RX_LANES-1:0]       rxd,
  output logic                      busy,
  output logic                      done,
  output logic [RX_LANES-1:0]       lock,
  output logic [RX_LANES*ERR_W-1:0] err_cnt
);

  localparam int unsigned CNT_W = $clog2(TEST_LEN + 1);
  localparam int unsigned LCK_W = $clog2(LOCK_CNT + 1);

  localparam logic [1:0] MODE_TOGGLE = 2'd1;
  localparam logic [1:0] MODE_PASS   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_DONE
  } state_t;

  state_t               r_state;
  logic [1:0]           r_mode_q;
  logic [6:0]           r_lfsr;
  logic                 r_toggle;
  logic [CNT_W-1:0]     r_cyc;

  logic [6:0]           r_shift [RX_LANES];
  logic [LCK_W-1:0]     r_lcnt  [RX_LANES];
  logic [ERR_W-1:0]     r_err   [RX_LANES];
  logic [RX_LANES-1:0]  r_lock;

  logic [TX_LANES-1:0]  w_gen;
  logic [RX_LANES-1:0]  w_match;
  logic                 w_chk_en;

  // Generator lane values: PRBS lane i taps lfsr bit i; toggle lanes alternate phase
  always_comb begin
    w_gen = '0;
    for (int i = 0; i < int'(TX_LANES); i++) begin
      w_gen[i] = (r_mode_q == MODE_TOGGLE) ? (r_toggle ^ 1'(i)) : r_lfsr[i];
    end
  end

  // Per-lane pattern predictors compare the new bit against recent history
  always_comb begin
    w_match = '0;
    for (int k = 0; k < int'(RX_LANES); k++) begin
      if (r_mode_q == MODE_TOGGLE) begin
        w_match[k] = (rxd[k] != r_shift[k][0]);
      end else begin
        w_match[k] = (rxd[k] == (r_shift[k][6] ^ r_shift[k][5]));
      end
    end
  end

  assign w_chk_en = (r_state == S_RUN) && (r_mode_q != MODE_PASS);

  // Sequencer, pattern generator and registered lane outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mode_q <= 2'd0;
      r_lfsr   <= 7'h7F;
      r_toggle <= 1'b0;
      r_cyc    <= '0;
      txd      <= '0;
      pin_rxd  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done    <= 1'b0;
      pin_rxd <= rxd[0];

      case (r_state)
        S_IDLE: begin
          r_mode_q <= pat_mode;
          if (start) begin
            r_state <= S_ARM;
            busy    <= 1'b1;
          end
        end
        S_ARM: begin
          r_lfsr   <= 7'h7F;
          r_toggle <= 1'b0;
          r_cyc    <= '0;
          r_state  <= S_RUN;
        end
        S_RUN: begin
          if (r_cyc == CNT_W'(TEST_LEN - 1)) begin
            r_state <= S_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end else begin
            r_cyc <= r_cyc + 1'b1;
          end
          if (r_mode_q != MODE_PASS) begin
            r_lfsr   <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
            r_toggle <= ~r_toggle;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (r_mode_q == MODE_PASS) begin
        txd <= pin_txd;
      end else if (r_state == S_RUN) begin
        txd <= w_gen;
      end else begin
        txd <= '0;
      end
    end
  end

  // Receive checkers: lock after LOCK_CNT clean matches, then count errors
  always_ff @(posedge clk) begin
    if (rst || (r_state == S_ARM)) begin
      r_lock <= '0;
      for (int k = 0; k < int'(RX_LANES); k++) begin
        r_shift[k] <= '0;
        r_lcnt[k]  <= '0;
        r_err[k]   <= '0;
      end
    end else if (w_chk_en) begin
      for (int k = 0; k < int'(RX_LANES); k++) begin
        r_shift[k] <= {r_shift[k][5:0], rxd[k]};
        if (!r_lock[k]) begin
          if (w_match[k]) begin
            r_lcnt[k] <= r_lcnt[k] + 1'b1;
            if (r_lcnt[k] == LCK_W'(LOCK_CNT - 1)) begin
              r_lock[k] <= 1'b1;
            end
          end else begin
            r_lcnt[k] <= '0;
          end
        end else if (!w_match[k] && (r_err[k] != {ERR_W{1'b1}})) begin
          r_err[k] <= r_err[k] + 1'b1;
        end
      end
    end
  end

  assign lock = r_lock;

  for (genvar k = 0; k < int'(RX_LANES); k++) begin : g_err
    assign err_cnt[k*ERR_W +: ERR_W] = r_err[k];
  end

endmodule

// File: tb/tb_pin_link_test.sv
// Self-checking bench for pin_link_test: passthrough vector table, full test
// runs with a result scoreboard, reset mid-run and error-counter saturation.
module tb_pin_link_test;

  logic        clk;
  logic        rst;
  logic        start;
  logic [1:0]  pat_mode;
  logic [3:0]  pin_txd;
  logic        pin_rxd;
  logic [3:0]  txd;
  logic [1:0]  rxd;
  logic        busy;
  logic        done;
  logic [1:0]  lock;
  logic [31:0] err_cnt;

  logic [1:0]  lp_en;
  logic [1:0]  rx_val;
  logic        flip;

  logic        start2;
  logic [1:0]  pat_mode2;
  logic        pin_txd2;
  logic        pin_rxd2;
  logic        txd2;
  logic        rxd2;
  logic        busy2;
  logic        done2;
  logic        lock2;
  logic [3:0]  err2;
  logic        lp2;

  int n_cmp;
  int n_err;

  typedef struct {
    logic [1:0]  lock;
    logic [31:0] err;
  } res_t;
  res_t sb_q[$];

  typedef struct {
    logic [3:0] tx;
    logic       prx;
  } pex_t;
  pex_t pq[$];

  typedef struct {
    logic [1:0] mode;
    logic [3:0] pin;
    logic       rx;
    logic [3:0] e_txd;
    logic       e_prx;
  } vec_t;

  assign rxd[0] = lp_en[0] ? (txd[0] ^ flip) : rx_val[0];
  assign rxd[1] = lp_en[1] ? txd[1] : rx_val[1];
  assign rxd2   = lp2 ? txd2 : 1'b0;

  pin_link_test #(
    .TX_LANES(4), .RX_LANES(2), .TEST_LEN(100), .LOCK_CNT(8), .ERR_W(16)
  ) u_dut (
    .clk(clk), .rst(rst), .start(start), .pat_mode(pat_mode),
    .pin_txd(pin_txd), .pin_rxd(pin_rxd), .txd(txd), .rxd(rxd),
    .busy(busy), .done(done), .lock(lock), .err_cnt(err_cnt)
  );

  pin_link_test #(
    .TX_LANES(1), .RX_LANES(1), .TEST_LEN(60), .LOCK_CNT(4), .ERR_W(4)
  ) u_sat (
    .clk(clk), .rst(rst), .start(start2), .pat_mode(pat_mode2),
    .pin_txd(pin_txd2), .pin_rxd(pin_rxd2), .txd(txd2), .rxd(rxd2),
    .busy(busy2), .done(done2), .lock(lock2), .err_cnt(err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, wanted completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, wanted %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One full test on the main DUT; expected end results go through the scoreboard
  task automatic run_test(input string nm, input logic [1:0] mode, input logic [1:0] lpen,
                          input logic [1:0] rxv, input int flip_at,
                          input logic [1:0] e_lock, input logic [15:0] e0, input logic [15:0] e1);
    res_t r;
    res_t got;
    int busy_n;
    int done_n;
    int done_at;
    pat_mode = mode;
    lp_en    = lpen;
    rx_val   = rxv;
    tick(1);
    start  = 1'b1;
    r.lock = e_lock;
    r.err  = {e1, e0};
    sb_q.push_back(r);
    busy_n  = 0;
    done_n  = 0;
    done_at = 0;
    for (int i = 1; i <= 110; i++) begin
      @(negedge clk);
      start = 1'b0;
      flip  = (i == flip_at);
      if (busy) busy_n++;
      if (done) begin
        done_n++;
        done_at = i;
      end
      if (i == 18) chk({nm, " lock_by_run16"}, 64'(lock), 64'(e_lock));
    end
    flip = 1'b0;
    chk({nm, " busy_cycles"}, 64'(busy_n), 64'd101);
    chk({nm, " done_pulses"}, 64'(done_n), 64'd1);
    chk({nm, " done_latency"}, 64'(done_at), 64'd102);
    if (sb_q.size() == 0) begin
      chk({nm, " scoreboard_empty"}, 64'd0, 64'd1);
    end else begin
      got = sb_q.pop_front();
      chk({nm, " lock"}, 64'(lock), 64'(got.lock));
      chk({nm, " err_cnt"}, 64'(err_cnt), 64'(got.err));
    end
  endtask

  initial begin
    vec_t vt[9];
    logic [1:0] prev_mode;
    pex_t pe;
    int done_seen;
    int busy_seen;
    int w;

    vt[0] = '{mode: 2'd3, pin: 4'b1010, rx: 1'b1, e_txd: 4'b1010, e_prx: 1'b1};
    vt[1] = '{mode: 2'd3, pin: 4'b0101, rx: 1'b0, e_txd: 4'b0101, e_prx: 1'b0};
    vt[2] = '{mode: 2'd3, pin: 4'b1111, rx: 1'b1, e_txd: 4'b1111, e_prx: 1'b1};
    vt[3] = '{mode: 2'd3, pin: 4'b0000, rx: 1'b1, e_txd: 4'b0000, e_prx: 1'b1};
    vt[4] = '{mode: 2'd3, pin: 4'b1001, rx: 1'b0, e_txd: 4'b1001, e_prx: 1'b0};
    vt[5] = '{mode: 2'd0, pin: 4'b1111, rx: 1'b1, e_txd: 4'b0000, e_prx: 1'b1};
    vt[6] = '{mode: 2'd0, pin: 4'b0110, rx: 1'b0, e_txd: 4'b0000, e_prx: 1'b0};
    vt[7] = '{mode: 2'd1, pin: 4'b1010, rx: 1'b1, e_txd: 4'b0000, e_prx: 1'b1};
    vt[8] = '{mode: 2'd2, pin: 4'b0101, rx: 1'b0, e_txd: 4'b0000, e_prx: 1'b0};

    n_cmp     = 0;
    n_err     = 0;
    rst       = 1'b1;
    start     = 1'b0;
    pat_mode  = 2'd0;
    pin_txd   = 4'b1111;
    lp_en     = 2'b00;
    rx_val    = 2'b11;
    flip      = 1'b0;
    start2    = 1'b0;
    pat_mode2 = 2'd1;
    pin_txd2  = 1'b1;
    lp2       = 1'b1;

    tick(3);
    chk("rst txd", 64'(txd), 64'd0);
    chk("rst pin_rxd", 64'(pin_rxd), 64'd0);
    chk("rst busy", 64'(busy), 64'd0);
    chk("rst done", 64'(done), 64'd0);
    chk("rst lock", 64'(lock), 64'd0);
    chk("rst err_cnt", 64'(err_cnt), 64'd0);
    chk("rst sat err", 64'(err2), 64'd0);
    rst = 1'b0;
    tick(1);

    // Passthrough / idle vector table
    prev_mode = 2'd0;
    for (int i = 0; i < 9; i++) begin
      pat_mode = vt[i].mode;
      if (vt[i].mode != prev_mode) tick(1);
      prev_mode = vt[i].mode;
      pin_txd   = vt[i].pin;
      rx_val[0] = vt[i].rx;
      pe.tx  = vt[i].e_txd;
      pe.prx = vt[i].e_prx;
      pq.push_back(pe);
      @(negedge clk);
      pe = pq.pop_front();
      chk($sformatf("vec%0d txd", i), 64'(txd), 64'(pe.tx));
      chk($sformatf("vec%0d pin_rxd", i), 64'(pin_rxd), 64'(pe.prx));
    end
    pin_txd  = 4'b1010;
    pat_mode = 2'd0;
    tick(2);

    run_test("prbs_loop",   2'd0, 2'b11, 2'b00, 0,  2'b11, 16'd0, 16'd0);
    run_test("prbs_flip",   2'd0, 2'b11, 2'b00, 40, 2'b11, 16'd3, 16'd0);
    run_test("toggle_loop", 2'd1, 2'b11, 2'b00, 0,  2'b11, 16'd0, 16'd0);
    run_test("toggle_stuck",2'd1, 2'b10, 2'b00, 0,  2'b10, 16'd0, 16'd0);
    run_test("mode2_prbs",  2'd2, 2'b11, 2'b00, 0,  2'b11, 16'd0, 16'd0);
    run_test("passthru",    2'd3, 2'b11, 2'b00, 0,  2'b00, 16'd0, 16'd0);
    chk("passthru txd", 64'(txd), 64'(4'b1010));

    // Reset at RUN cycle 50
    pat_mode = 2'd0;
    lp_en    = 2'b11;
    tick(1);
    start = 1'b1;
    for (int i = 1; i <= 51; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    chk("pre_rst lock", 64'(lock), 64'(2'b11));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst txd", 64'(txd), 64'd0);
    chk("midrst pin_rxd", 64'(pin_rxd), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    chk("midrst lock", 64'(lock), 64'd0);
    chk("midrst err_cnt", 64'(err_cnt), 64'd0);
    rst = 1'b0;
    done_seen = 0;
    busy_seen = 0;
    for (int i = 0; i < 120; i++) begin
      @(negedge clk);
      if (done) done_seen++;
      if (busy) busy_seen++;
    end
    chk("midrst no_done", 64'(done_seen), 64'd0);
    chk("midrst idle", 64'(busy_seen), 64'd0);
    run_test("after_rst", 2'd0, 2'b11, 2'b00, 0, 2'b11, 16'd0, 16'd0);

    // Saturating error counter on the narrow instance
    lp2 = 1'b1;
    tick(2);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    w = 0;
    while (!lock2 && w < 40) begin
      @(negedge clk);
      w++;
    end
    chk("sat lock_reached", 64'(lock2), 64'd1);
    lp2 = 1'b0;
    w = 0;
    while (!done2 && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk("sat done_seen", 64'(done2), 64'd1);
    chk("sat err_at_done", 64'(err2), 64'd15);
    tick(5);
    chk("sat err_hold", 64'(err2), 64'd15);
    chk("sat lock_hold", 64'(lock2), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
